// File: rtl/sdi_rx_align_if.sv
// sdi_rx_align_if: serial input and aligned-word outputs of the SDI receive aligner.
// master: stream source / consumer side; slave: the aligner itself.
interface sdi_rx_align_if #(
    parameter int LINE_W = 11
);
    logic              sdi_in;
    logic [9:0]        word_data;
    logic              word_valid;
    logic              locked;
    logic              trs_eav;
    logic              trs_sav;
    logic              v_sync;
    logic              field;
    logic              a_valid;
    logic [LINE_W-1:0] line_cnt;
    logic              align_err;

    modport master (
        output sdi_in,
        input  word_data, word_valid, locked, trs_eav, trs_sav,
        input  v_sync, field, a_valid, line_cnt, align_err
    );

    modport slave (
        input  sdi_in,
        output word_data, word_valid, locked, trs_eav, trs_sav,
        output v_sync, field, a_valid, line_cnt, align_err
    );
endinterface

// File: rtl/sdi_rx_align.sv
// sdi_rx_align: SDI serial-to-word aligner.
// Finds TRS (3FF,000,000) in the serial stream, locks word alignment after
// LOCK_TRS same-phase TRS, emits aligned words, decodes XYZ (EAV/SAV, F, V),
// counts lines and flags ancillary data flags.
// Optional macro SDI_RX_XYZ_CHECK_EN: accept XYZ words only when their
// protection bits are consistent; otherwise any XYZ with bit9=1 is accepted.
module sdi_rx_align #(
    parameter int LOCK_TRS = 2,
    parameter int LINE_W   = 11
) (
    input  logic          clk,
    input  logic          rst,
    sdi_rx_align_if.slave bus
);

    if (LOCK_TRS < 1 || LOCK_TRS > 7) begin : g_bad_lock_trs
        $error("sdi_rx_align: LOCK_TRS must be in 1..7");
    end

    // Oldest word sits in the low bits because bits arrive LSB first.
    localparam logic [29:0] TRS_PAT = {10'h000, 10'h000, 10'h3FF};
    localparam logic [29:0] ADF_PAT = {10'h3FF, 10'h3FF, 10'h000};
    localparam logic [2:0]  LOCK_N  = 3'(LOCK_TRS);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t            r_state;
    logic [29:0]       r_hist;
    logic [3:0]        r_phase;
    logic [2:0]        r_match;
    logic [2:0]        r_miss;
    logic              r_xyz_next;
    logic              r_locked;
    logic [9:0]        r_word_data;
    logic              r_word_valid;
    logic              r_trs_eav;
    logic              r_trs_sav;
    logic              r_v_sync;
    logic              r_field;
    logic              r_a_valid;
    logic [LINE_W-1:0] r_line_cnt;
    logic              r_align_err;

    logic [29:0]       w_hist;
    logic [9:0]        w_word;
    logic              w_trs;
    logic              w_adf;
    logic              w_bound;
    logic [3:0]        w_phase_inc;
    logic [2:0]        w_match_inc;
    logic [2:0]        w_miss_inc;
    logic              w_xyz_ok;
    logic              w_f;
    logic              w_v;
    logic              w_h;

    // History including the bit being sampled this cycle, so detection
    // happens on the same edge as the last bit of a pattern.
    assign w_hist      = {bus.sdi_in, r_hist[29:1]};
    assign w_word      = w_hist[29:20];
    assign w_trs       = (w_hist == TRS_PAT);
    assign w_adf       = (w_hist == ADF_PAT);
    assign w_bound     = (r_phase == 4'd9);
    assign w_phase_inc = w_bound ? 4'd0 : r_phase + 4'd1;
    assign w_match_inc = r_match + 3'd1;
    assign w_miss_inc  = r_miss + 3'd1;
    assign w_f         = w_word[8];
    assign w_v         = w_word[7];
    assign w_h         = w_word[6];

`ifdef SDI_RX_XYZ_CHECK_EN
    assign w_xyz_ok = w_word[9]
                   && (w_word[5:2] == {w_v ^ w_h, w_f ^ w_h, w_f ^ w_v, w_f ^ w_v ^ w_h})
                   && (w_word[1:0] == 2'b00);
`else
    assign w_xyz_ok = w_word[9];
`endif

    // Alignment FSM, word output, XYZ decode and line counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SEARCH;
            r_hist       <= '0;
            r_phase      <= '0;
            r_match      <= '0;
            r_miss       <= '0;
            r_xyz_next   <= 1'b0;
            r_locked     <= 1'b0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_trs_eav    <= 1'b0;
            r_trs_sav    <= 1'b0;
            r_v_sync     <= 1'b0;
            r_field      <= 1'b0;
            r_a_valid    <= 1'b0;
            r_line_cnt   <= '0;
            r_align_err  <= 1'b0;
        end else begin
            r_hist       <= w_hist;
            r_phase      <= w_phase_inc;
            r_word_valid <= 1'b0;
            r_trs_eav    <= 1'b0;
            r_trs_sav    <= 1'b0;
            r_a_valid    <= 1'b0;
            r_align_err  <= 1'b0;
            // The XYZ flag covers exactly one word after an aligned TRS.
            if (w_bound) begin
                r_xyz_next <= 1'b0;
            end

            unique case (r_state)
                SEARCH: begin
                    if (w_trs) begin
                        r_phase    <= 4'd0;
                        r_xyz_next <= 1'b1;
                        r_miss     <= '0;
                        r_match    <= 3'd1;
                        if (LOCK_N == 3'd1) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    if (w_trs) begin
                        r_xyz_next <= 1'b1;
                        if (w_bound) begin
                            r_match <= w_match_inc;
                            if (w_match_inc == LOCK_N) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_miss   <= '0;
                            end
                        end else begin
                            r_phase <= 4'd0;
                            r_match <= 3'd1;
                        end
                    end
                end

                LOCKED: begin
                    if (w_bound) begin
                        r_word_valid <= 1'b1;
                        r_word_data  <= w_word;
                        r_a_valid    <= w_adf;
                        if (r_xyz_next && w_xyz_ok) begin
                            r_v_sync <= w_v;
                            r_field  <= w_f;
                            if (w_h) begin
                                r_trs_eav <= 1'b1;
                                if (w_f != r_field) begin
                                    r_line_cnt <= '0;
                                end else if (r_line_cnt != '1) begin
                                    r_line_cnt <= r_line_cnt + 1'b1;
                                end
                            end else begin
                                r_trs_sav <= 1'b1;
                            end
                        end
                    end
                    if (w_trs) begin
                        if (w_bound) begin
                            r_miss     <= '0;
                            r_xyz_next <= 1'b1;
                        end else if (w_miss_inc == LOCK_N) begin
                            // Realign on the new phase; that TRS counts as the first match.
                            r_align_err <= 1'b1;
                            r_phase     <= 4'd0;
                            r_xyz_next  <= 1'b1;
                            r_miss      <= '0;
                            r_match     <= 3'd1;
                            if (LOCK_N == 3'd1) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_state  <= VERIFY;
                                r_locked <= 1'b0;
                            end
                        end else begin
                            r_miss <= w_miss_inc;
                        end
                    end
                end

                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_data  = r_word_data;
    assign bus.word_valid = r_word_valid;
    assign bus.locked     = r_locked;
    assign bus.trs_eav    = r_trs_eav;
    assign bus.trs_sav    = r_trs_sav;
    assign bus.v_sync     = r_v_sync;
    assign bus.field      = r_field;
    assign bus.a_valid    = r_a_valid;
    assign bus.line_cnt   = r_line_cnt;
    assign bus.align_err  = r_align_err;

endmodule

// File: tb/tb_sdi_rx_align.sv
// tb_sdi_rx_align: directed scenario with random payload words for sdi_rx_align.
// The reference model works on absolute bit positions of TRS endings.
module tb_sdi_rx_align;

    localparam int LOCK_TRS = 2;
    localparam int LINE_W   = 11;

    logic clk = 1'b0;
    logic rst;

    sdi_rx_align_if #(.LINE_W(LINE_W)) bus ();

    sdi_rx_align #(.LOCK_TRS(LOCK_TRS), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;

    // Reference model state.
    int         idx;        // index of the next bit to be sent
    int         m_ref;      // bit index of the TRS end that defines alignment
    int         m_cnt;      // same-phase TRS seen while not locked (0 = searching)
    int         m_miss;     // wrong-phase TRS seen while locked
    bit         m_locked;
    bit         m_err;
    bit         m_xyz_pos;  // next word is an XYZ the receiver may accept
    logic [9:0] m_last10;   // last 10 bits sent, newest in bit 9
    bit         m_f;
    bit         m_v;
    int         m_line;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mk_xyz(input bit f, input bit v, input bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
    endfunction

    task automatic model_reset();
        idx = 0; m_ref = 0; m_cnt = 0; m_miss = 0;
        m_locked = 0; m_err = 0; m_xyz_pos = 0; m_last10 = '0;
        m_f = 0; m_v = 0; m_line = 0;
    endtask

    // Lock bookkeeping when a TRS ends at bit index e.
    task automatic model_trs(input int e);
        if (!m_locked) begin
            if (m_cnt > 0 && ((e - m_ref) % 10) == 0) m_cnt++;
            else m_cnt = 1;
            m_ref = e;
            m_xyz_pos = 1;
            if (m_cnt >= LOCK_TRS) begin
                m_locked = 1;
                m_miss = 0;
            end
        end else if (((e - m_ref) % 10) == 0) begin
            m_miss = 0;
            m_xyz_pos = 1;
        end else begin
            m_miss++;
            m_xyz_pos = 0;
            if (m_miss == LOCK_TRS) begin
                m_err = 1;
                m_miss = 0;
                m_cnt = 1;
                m_ref = e;
                m_xyz_pos = 1;
                m_locked = (LOCK_TRS == 1);
            end
        end
    endtask

    task automatic send_bit(input logic b, input bit trs_end);
        bit exp_wv;
        bus.sdi_in = b;
        @(posedge clk);
        #1;
        m_err = 0;
        exp_wv = m_locked && (((idx - m_ref) % 10) == 0);
        m_last10 = {b, m_last10[9:1]};
        if (trs_end) model_trs(idx);
        chk("word_valid", 32'(bus.word_valid), 32'(exp_wv));
        if (exp_wv) chk("word_data", 32'(bus.word_data), 32'(m_last10));
        chk("locked", 32'(bus.locked), 32'(m_locked));
        chk("align_err", 32'(bus.align_err), 32'(m_err));
        idx++;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) send_word(10'($urandom_range(10'h3FE, 1)));
    endtask

    task automatic send_trs();
        logic [9:0] w3ff;
        w3ff = 10'h3FF;
        for (int i = 0; i < 10; i++) send_bit(w3ff[i], 1'b0);
        for (int i = 0; i < 19; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
    endtask

    task automatic send_xyz(input logic [9:0] w);
        bit acc;
        bit f;
        bit v;
        bit h;
        send_word(w);
        f = w[8]; v = w[7]; h = w[6];
        acc = m_locked && m_xyz_pos && w[9];
`ifdef SDI_RX_XYZ_CHECK_EN
        acc = acc && (w[5:2] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h}) && (w[1:0] == 2'b00);
`endif
        if (acc) begin
            if (h) begin
                if (f != m_f) m_line = 0;
                else if (m_line < (1 << LINE_W) - 1) m_line++;
            end
            m_f = f;
            m_v = v;
        end
        m_xyz_pos = 0;
        chk("trs_eav", 32'(bus.trs_eav), 32'(acc && h));
        chk("trs_sav", 32'(bus.trs_sav), 32'(acc && !h));
        chk("v_sync", 32'(bus.v_sync), 32'(m_v));
        chk("field", 32'(bus.field), 32'(m_f));
        chk("line_cnt", 32'(bus.line_cnt), 32'(m_line));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_word_data", 32'(bus.word_data), 32'h0);
        chk("rst_word_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_locked", 32'(bus.locked), 32'h0);
        chk("rst_trs_eav", 32'(bus.trs_eav), 32'h0);
        chk("rst_trs_sav", 32'(bus.trs_sav), 32'h0);
        chk("rst_v_sync", 32'(bus.v_sync), 32'h0);
        chk("rst_field", 32'(bus.field), 32'h0);
        chk("rst_a_valid", 32'(bus.a_valid), 32'h0);
        chk("rst_line_cnt", 32'(bus.line_cnt), 32'h0);
        chk("rst_align_err", 32'(bus.align_err), 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.sdi_in = 1'b0;
        rst = 1'b1;
        model_reset();

        // Reset state, then unlocked idle stream.
        do_reset();
        send_line(3);

        // Two TRS at 10-bit spacing lock the aligner; second XYZ decoded.
        send_trs();
        send_xyz(10'h274);
        send_line(4);
        send_trs();
        send_xyz(10'h274);
        chk("lock_eav", 32'(bus.trs_eav), 32'h1);

        // Random payload while locked.
        send_line(8);

        // Ancillary data flag.
        send_word(10'h000);
        chk("adf_w1", 32'(bus.a_valid), 32'h0);
        send_word(10'h3FF);
        chk("adf_w2", 32'(bus.a_valid), 32'h0);
        send_word(10'h3FF);
        chk("adf_w3", 32'(bus.a_valid), 32'h1);
        send_line(2);

        // SAV.
        send_trs();
        send_xyz(mk_xyz(1'b0, 1'b0, 1'b0));
        send_line(2);

        // EAVs in field 0 up to line 5, then an EAV in field 1.
        while (m_line < 5) begin
            send_trs();
            send_xyz(mk_xyz(1'b0, 1'($urandom_range(1, 0)), 1'b1));
            send_line(2);
        end
        chk("line_five", 32'(bus.line_cnt), 32'd5);
        send_trs();
        send_xyz(mk_xyz(1'b1, 1'($urandom_range(1, 0)), 1'b1));
        chk("line_wrap", 32'(bus.line_cnt), 32'd0);
        send_line(2);

        // XYZ with inconsistent protection bits.
        send_trs();
        send_xyz(10'h27C);
`ifdef SDI_RX_XYZ_CHECK_EN
        chk("bad_xyz_eav", 32'(bus.trs_eav), 32'h0);
`else
        chk("bad_xyz_eav", 32'(bus.trs_eav), 32'h1);
`endif
        send_line(2);

        // Shift the stream by 3 bits: two misplaced TRS force realignment.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
        send_trs();
        send_xyz(mk_xyz(1'b0, 1'b0, 1'b1));
        send_line(3);
        send_trs();
        chk("realign_err", 32'(bus.align_err), 32'h1);
        send_xyz(mk_xyz(1'b0, 1'b0, 1'b1));
        send_line(2);
        send_trs();
        chk("relock", 32'(bus.locked), 32'h1);
        send_xyz(mk_xyz(1'b0, 1'b1, 1'b1));
        send_line(3);

        // Reset in the middle of a word while locked.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
        do_reset();
        send_line(2);
        send_trs();
        chk("post_rst_search", 32'(bus.locked), 32'h0);
        send_xyz(10'h274);
        send_line(1);
        send_trs();
        send_xyz(mk_xyz(1'b1, 1'b0, 1'b1));
        send_line(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
